// File: rtl/cu.sv
// Multi-cycle control unit: FETCH/EXEC sequencing, instruction decode for the
// function unit and register file, Z/N flag register and branch resolution.
module cu #(
   parameter int PC_WIDTH = 8
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic [15:0]         instr_in,
   input  logic                z_in,
   input  logic                n_in,
   output logic [PC_WIDTH-1:0] pc_out,
   output logic [3:0]          fs_out,
   output logic [2:0]          a_sel_out,
   output logic [2:0]          b_sel_out,
   output logic [2:0]          d_sel_out,
   output logic [15:0]         imm_out,
   output logic                b_imm_sel_out,
   output logic                rf_we_out,
   output logic                halt_out
);

   typedef enum logic [1:0] {FETCH, EXEC, HALT} state_e;

   state_e              state_q, state_d;
   logic [15:0]         ir_q, ir_d;
   logic [PC_WIDTH-1:0] pc_q, pc_d;
   logic                z_q, z_d, n_q, n_d;

   logic                is_alu, is_br, is_halt, taken;
   logic [PC_WIDTH-1:0] pc_inc, pc_br;

   assign is_alu  = ~ir_q[15];
   assign is_br   = (ir_q[15:14] == 2'b10);
   assign is_halt = (ir_q[15:12] == 4'b1100);

   always_comb begin
      taken = 1'b0;
      case (ir_q[13:12])
         2'b00: taken = 1'b1;
         2'b01: taken = z_q;
         2'b10: taken = n_q;
         2'b11: taken = ~z_q;
         default: taken = 1'b0;
      endcase
   end

   // Sized cast sign-extends (or truncates) the 8-bit offset to the PC width.
   assign pc_inc = pc_q + PC_WIDTH'(1);
   assign pc_br  = pc_inc + PC_WIDTH'($signed(ir_q[7:0]));

   always_comb begin
      state_d = state_q;
      ir_d    = ir_q;
      pc_d    = pc_q;
      z_d     = z_q;
      n_d     = n_q;
      case (state_q)
         FETCH: begin
            ir_d    = instr_in;
            state_d = EXEC;
         end
         EXEC: begin
            if (is_halt) begin
               state_d = HALT;
            end else begin
               state_d = FETCH;
               pc_d    = (is_br && taken) ? pc_br : pc_inc;
            end
            if (is_alu) begin
               z_d = z_in;
               n_d = n_in;
            end
         end
         HALT: state_d = HALT;
         default: state_d = FETCH;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= FETCH;
         ir_q    <= 16'hF000;
         pc_q    <= '0;
         z_q     <= 1'b0;
         n_q     <= 1'b0;
      end else begin
         state_q <= state_d;
         ir_q    <= ir_d;
         pc_q    <= pc_d;
         z_q     <= z_d;
         n_q     <= n_d;
      end
   end

   assign pc_out        = pc_q;
   assign fs_out        = is_alu ? ir_q[14:11] : 4'd0;
   assign d_sel_out     = ir_q[10:8];
   assign a_sel_out     = ir_q[7:5];
   assign b_sel_out     = ir_q[3:1];
   assign imm_out       = {{12{ir_q[3]}}, ir_q[3:0]};
   assign b_imm_sel_out = is_alu & ir_q[4];
   assign rf_we_out     = (state_q == EXEC) && is_alu;
   assign halt_out      = (state_q == HALT);

endmodule

// File: tb/tb_cu.sv
// Directed bench for cu: instruction memory array and driven flag inputs,
// outputs sampled on the falling edge.
module tb_cu;
   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [15:0] instr_in;
   logic        z_in = 1'b0, n_in = 1'b0;
   logic [7:0]  pc_out;
   logic [3:0]  fs_out;
   logic [2:0]  a_sel_out, b_sel_out, d_sel_out;
   logic [15:0] imm_out;
   logic        b_imm_sel_out, rf_we_out, halt_out;

   logic [15:0] mem [256];
   int checks = 0, errors = 0;

   always #5 clk = ~clk;
   assign instr_in = mem[pc_out];

   cu #(.PC_WIDTH(8)) dut (
      .clk(clk), .rst_n(rst_n), .instr_in(instr_in), .z_in(z_in), .n_in(n_in),
      .pc_out(pc_out), .fs_out(fs_out), .a_sel_out(a_sel_out),
      .b_sel_out(b_sel_out), .d_sel_out(d_sel_out), .imm_out(imm_out),
      .b_imm_sel_out(b_imm_sel_out), .rf_we_out(rf_we_out), .halt_out(halt_out)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic clr_mem();
      for (int i = 0; i < 256; i++) mem[i] = 16'hF000;
   endtask

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      @(negedge clk);
   endtask

   // Reset held across a clock edge, released on a falling edge.
   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   logic [15:0] br_op [3];
   logic        br_z  [3];
   logic        br_n  [3];
   int          we_seen;

   initial begin
      clr_mem();
      mem[0] = 16'h0A58;
      #2;
      chk("rst_pc", pc_out, 0);
      chk("rst_we", rf_we_out, 0);
      chk("rst_halt", halt_out, 0);
      chk("rst_fs", fs_out, 0);
      chk("rst_bimm", b_imm_sel_out, 0);
      chk("rst_imm", imm_out, 0);
      chk("rst_sel", {a_sel_out, b_sel_out, d_sel_out}, 0);
      @(negedge clk);
      rst_n = 1'b1;

      // ALU immediate: EXEC is the cycle after the first edge
      step(1);
      chk("alu_we", rf_we_out, 1);
      chk("alu_fs", fs_out, 1);
      chk("alu_d", d_sel_out, 2);
      chk("alu_a", a_sel_out, 2);
      chk("alu_bimm", b_imm_sel_out, 1);
      chk("alu_imm", imm_out, 16'hFFF8);
      chk("alu_pc_exec", pc_out, 0);
      step(1);
      chk("alu_we_off", rf_we_out, 0);
      chk("alu_pc_next", pc_out, 1);

      // ALU register form: fs=3 d=5 a=6 b=7
      clr_mem();
      mem[0] = 16'h1DCE;
      do_reset();
      step(1);
      chk("alur_fs", fs_out, 3);
      chk("alur_dab", {d_sel_out, a_sel_out, b_sel_out}, {3'd5, 3'd6, 3'd7});
      chk("alur_bimm", b_imm_sel_out, 0);
      chk("alur_imm", imm_out, 16'hFFFE);

      // conditional branches after an ALU op; BR at pc=1 with off=+4
      br_op[0] = 16'h9004; br_z[0] = 1'b1; br_n[0] = 1'b0;
      br_op[1] = 16'hA004; br_z[1] = 1'b0; br_n[1] = 1'b1;
      br_op[2] = 16'hB004; br_z[2] = 1'b0; br_n[2] = 1'b0;
      for (int k = 0; k < 3; k++) begin
         for (int t = 0; t < 2; t++) begin
            clr_mem();
            mem[0] = 16'h0A58;
            mem[1] = br_op[k];
            z_in = (t == 0) ? br_z[k] : ~br_z[k];
            n_in = (t == 0) ? br_n[k] : ~br_n[k];
            do_reset();
            step(3);
            if (k == 0 && t == 0) chk("br_fs_gated", fs_out, 0);
            step(1);
            chk($sformatf("br%0d_t%0d_pc", k, t), pc_out, (t == 0) ? 6 : 2);
         end
      end

      // flags survive a non-ALU instruction between ALU and branch
      clr_mem();
      mem[0] = 16'h0A58;
      mem[2] = 16'h9004;
      z_in = 1'b1; n_in = 1'b0;
      do_reset();
      step(2);
      z_in = 1'b0;
      step(4);
      chk("flag_hold_pc", pc_out, 7);

      // tight self-loop at pc=5
      clr_mem();
      mem[5] = 16'h80FF;
      do_reset();
      step(10);
      chk("loop_reach", pc_out, 5);
      we_seen = 0;
      for (int i = 0; i < 20; i++) begin
         step(1);
         if (pc_out != 8'd5 || rf_we_out) we_seen++;
      end
      chk("loop_stuck", we_seen, 0);

      // wrap from 255 to 0
      clr_mem();
      do_reset();
      step(510);
      chk("wrap_255", pc_out, 255);
      step(2);
      chk("wrap_0", pc_out, 0);

      // branch below 0
      clr_mem();
      mem[1] = 16'h80FD;
      do_reset();
      step(4);
      chk("br_under", pc_out, 255);

      // HALT at pc=3
      clr_mem();
      mem[3] = 16'hC000;
      do_reset();
      step(7);
      chk("halt_exec", halt_out, 0);
      chk("halt_we", rf_we_out, 0);
      step(1);
      chk("halt_on", halt_out, 1);
      chk("halt_pc", pc_out, 3);
      step(6);
      chk("halt_sticky", halt_out, 1);
      chk("halt_pc_hold", pc_out, 3);
      #2 rst_n = 1'b0;
      #1;
      chk("halt_rst", halt_out, 0);
      chk("halt_rst_pc", pc_out, 0);

      // reset during ALU EXEC drops the write and leaves flags at 0
      clr_mem();
      mem[0] = 16'h0A58;
      z_in = 1'b1;
      do_reset();
      step(1);
      chk("mid_we", rf_we_out, 1);
      #2 rst_n = 1'b0;
      #1;
      chk("mid_we_drop", rf_we_out, 0);
      chk("mid_pc", pc_out, 0);
      mem[0] = 16'h9004;
      z_in = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      step(2);
      chk("mid_flags", pc_out, 1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/cu.md
# cu

Multi-cycle control unit for the mycpu datapath. It fetches 16-bit instructions, decodes them, and drives the function unit's `fs_in`, the register-file read/write selects and the immediate mux. It holds the Z/N flag register fed from the function unit's `z_out`/`n_out` and uses it to resolve conditional branches. It sits directly upstream of `fu` and consumes its flag outputs.

## Interface
Parameters:
- `PC_WIDTH`, default 8: program counter / instruction address width.

Ports:
- `clk`  in  1: system clock; all state updates on the rising edge.
- `rst_n`  in  1: reset, asynchronous, active-low.
- `instr_in`  in  16: instruction memory read data at `pc_out`, combinational.
- `z_in`  in  1: zero flag from `fu` `z_out`.
- `n_in`  in  1: negative flag from `fu` `n_out`.
- `pc_out`  out  PC_WIDTH: instruction address.
- `fs_out`  out  4: function select to `fu` `fs_in`.
- `a_sel_out`  out  3: register-file read port A address (to `fu` `a_in`).
- `b_sel_out`  out  3: register-file read port B address.
- `d_sel_out`  out  3: register-file write address.
- `imm_out`  out  16: sign-extended immediate.
- `b_imm_sel_out`  out  1: 1 = `fu` `b_in` takes `imm_out`; 0 = it takes read port B.
- `rf_we_out`  out  1: register-file write enable; the write of `fu` `f_out` happens at the clock edge.
- `halt_out`  out  1: processor halted.

## Operation
- Encoding of the instruction register `ir`:
  - ALU, `ir[15]=0`: `fs=ir[14:11]`, `d=ir[10:8]`, `a=ir[7:5]`, `I=ir[4]`. If `I=0`, `b=ir[3:1]`. If `I=1`, `imm=sext(ir[3:0])`.
  - BR, `ir[15:14]=10`: `cond=ir[13:12]` (00 always, 01 Z=1, 10 N=1, 11 Z=0), `off=ir[7:0]` signed.
  - SYS, `ir[15:14]=11`: `ir[13:12]=00` is HALT; any other value is NOP.
- States:
  - FETCH: `ir <= instr_in`; next state EXEC.
  - EXEC: execute `ir`. Next state is HALT for a HALT instruction, otherwise FETCH.
  - HALT: sticky; only `rst_n` exits it.
- Output decoding (combinational from `ir` and state):
  - `fs_out=ir[14:11]` for ALU instructions, else 0.
  - `a_sel_out`, `d_sel_out` and `b_sel_out` always come from their `ir` fields.
  - `imm_out=sext(ir[3:0])`.
  - `b_imm_sel_out=ir[4]` for ALU instructions, else 0.
- `rf_we_out` = 1 only in EXEC with an ALU instruction.
- Flags: at the end of EXEC of an ALU instruction, `z_q <= z_in` and `n_q <= n_in`. No other instruction changes the flags.
- PC update at the end of EXEC:
  - Taken branch: `pc <= pc + 1 + sext(off)`, modulo 2^PC_WIDTH.
  - Everything else except HALT: `pc <= pc + 1`, wrapping from max to 0.
  - HALT: pc holds.
- `halt_out` = 1 in the HALT state.

## Timing
- Reset values: state FETCH, `pc_out=0`, `ir=16'hF000` (NOP), `z_q=0`, `n_q=0`.
- Outputs during reset: `rf_we_out=0`, `halt_out=0`, `fs_out=0`, `b_imm_sel_out=0`, `imm_out=0`, all selects 0.
- Every instruction takes 2 cycles (FETCH, EXEC). The first FETCH is the first rising edge after `rst_n` deasserts.
- `instr_in` must be valid within the FETCH cycle for the current `pc_out`. `pc_out` changes only at the EXEC→FETCH edge.
- A branch in EXEC uses the flags written by the previous ALU instruction. This holds even when that instruction immediately precedes the branch, because the flags commit at the end of its EXEC.
- Mid-operation reset (any state, including HALT) returns immediately to the reset values, asynchronously. Any `rf_we_out` pulse in progress is dropped.
- Branch with `off=-1` (8'hFF) targets its own address, which gives a tight loop.
- Branch targets wrap both above the maximum address and below 0.

## Test plan
- Reset, then program 0:`0x0A58` (fs=1, d=2, a=2, I=1, imm=-8): `rf_we_out`=1 in cycle 2 only, `fs_out`=1, `d_sel_out`=2, `a_sel_out`=2, `b_imm_sel_out`=1, `imm_out`=16'hFFF8; `pc_out`=1 in cycle 3.
- ALU instruction with the fu model returning z=1, followed by BR cond=01, off=+4 at pc=1: `pc_out`=6 after the branch. Repeat with z=0: `pc_out`=2.
- BR cond=00, off=8'hFF at pc=5: `pc_out` stays 5 indefinitely and `rf_we_out` never asserts.
- PC_WIDTH=8, NOP at pc=255: next `pc_out`=0. BR off=-3 at pc=1: next `pc_out`=255.
- HALT (`0xC000`) at pc=3: `halt_out`=1 from the cycle after its EXEC and sticky; `pc_out`=3; `rf_we_out`=0. Asserting `rst_n`=0 clears `halt_out` and `pc_out` immediately.
- Assert `rst_n`=0 during the EXEC of an ALU instruction: `rf_we_out` drops without waiting for `clk`, flags stay 0, and execution restarts at pc=0.
